scr1_dmem_arb2: RTL
===================

Name: scr1_dmem_arb2

Overview:
- Two-requester arbiter in front of the data-memory AHB bridge core interface.
- Shares the single dmem port between requester 0 (core LSU) and requester 1 (debug/system-bus access).
- Round-robin or fixed-priority grant.
- Records the requester ID of each accepted transaction in an in-order tag FIFO, so each in-order bridge response returns to the requester that issued it.

Parameters:
- OUTST_DEPTH, 4, max accepted-but-unanswered transactions (tag FIFO depth, >=1).
- FIXED_PRIO, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
- rst_n  in  1  asynchronous reset, active-low.
- clk  in  1  clock.
- s0_req  in  1  requester 0 request.
- s0_req_ack  out  1  requester 0 request accepted this cycle.
- s0_cmd  in  type_scr1_mem_cmd_e  requester 0 read/write.
- s0_width  in  type_scr1_mem_width_e  requester 0 access width.
- s0_addr  in  32  requester 0 byte address.
- s0_wdata  in  32  requester 0 write data.
- s0_rdata  out  32  requester 0 read data.
- s0_resp  out  type_scr1_mem_resp_e  requester 0 response.
- s1_req, s1_req_ack, s1_cmd, s1_width, s1_addr, s1_wdata, s1_rdata, s1_resp: same as s0_*, for requester 1.
- m_req  out  1  request to bridge.
- m_req_ack  in  1  bridge accepts request.
- m_cmd  out  type_scr1_mem_cmd_e  forwarded cmd.
- m_width  out  type_scr1_mem_width_e  forwarded width.
- m_addr  out  32  forwarded address.
- m_wdata  out  32  forwarded write data.
- m_rdata  in  32  bridge read data.
- m_resp  in  type_scr1_mem_resp_e  bridge response.
- busy  out  1  at least one transaction outstanding.

Behaviour:
- Reset (async, rst_n low):
  - tag FIFO cleared (count=0, rd/wr pointers=0).
  - RR priority pointer = requester 0.
  - busy=0; s0_resp and s1_resp = SCR1_MEM_RESP_NOTRDY.
- Reset mid-operation discards all outstanding tags. Bridge responses arriving after reset release are treated as orphan responses (see below).
- Grant (combinational):
  - stall = (count == OUTST_DEPTH).
  - If only one requester asserts req, it is granted.
  - If both assert: FIXED_PRIO=1 grants requester 0; otherwise the requester holding RR priority is granted.
- Forwarding:
  - m_req = (s0_req | s1_req) & ~stall.
  - m_cmd, m_width, m_addr, m_wdata are muxed from the granted requester. They are driven to requester 0 values when no request is present.
  - m_req must be low while stalled: the bridge writes its FIFO on req & ~full.
- Acknowledge:
  - sX_req_ack = m_req_ack & grantX & ~stall.
  - Non-granted requester sees ack=0 and must hold req/cmd/addr/wdata stable.
  - Zero added latency on the request path.
- Accept = m_req & m_req_ack. On accept:
  - push granted ID into tag FIFO.
  - RR pointer moves to the other requester.
  - RR pointer is unchanged on cycles without accept.
- Response routing:
  - Response event = m_resp != NOTRDY (RDY_OK or RDY_ER) with count != 0.
  - Head tag selects the destination: that requester's resp = m_resp; the other requester sees NOTRDY.
  - On a response event, pop the tag FIFO.
  - s0_rdata = s1_rdata = m_rdata, unconditionally.
  - Response path is combinational, zero added latency.
- RDY_ER pops and routes exactly like RDY_OK. No retry, no flush of other outstanding tags.
- Orphan response (m_resp != NOTRDY while count == 0): both sX_resp = NOTRDY, no pop, state unchanged (simulation assertion fires).
- Simultaneous accept and response in one cycle:
  - Pop reads the old head; push writes the tail.
  - count unchanged.
  - This is legal when count == OUTST_DEPTH only if stall already blocks the accept, so no overflow is possible.
- Pointers wrap modulo OUTST_DEPTH.
- busy = (count != 0), registered-state based.
- Assertions:
  - no push when count == OUTST_DEPTH.
  - no X on m_req after reset.
  - sX_req_ack implies sX_req.

Test Plan:
- Single requester: s0 read addr 0x100 acked same cycle; bridge returns RDY_OK rdata 0xDEADBEEF two cycles later -> s0_resp=RDY_OK, s0_rdata=0xDEADBEEF, s1_resp=NOTRDY, busy 1 then 0.
- Contention, FIXED_PRIO=0: s0 and s1 assert continuously with m_req_ack=1 -> grants alternate 0,1,0,1. Four in-order responses route to 0,1,0,1 respectively.
- Contention, FIXED_PRIO=1: both assert for 3 cycles -> s0 acked all 3 cycles, s1_req_ack=0 throughout. s1 granted on the first cycle s0_req drops.
- Stall: OUTST_DEPTH=4, m_req_ack=1, no responses -> 4 accepts, then m_req=0 and both acks 0. One RDY_OK response -> next cycle m_req=1 again.
- Full + simultaneous: count=3, accept and response in the same cycle -> count stays 3, head advances, correct requester receives the response.
- Error and reset: s1 write gets RDY_ER -> s1_resp=RDY_ER, tag popped. Separately, assert rst_n=0 with count=2 -> busy=0 and a later response is dropped with both resp=NOTRDY.

Source files
------------

// File: rtl/scr1_memif_pkg.sv
// Memory-interface command, width and response encodings shared by the core and bridge ports.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_arb2.sv
// Two-requester arbiter sharing the dmem bridge port; an in-order tag FIFO steers each
// bridge response back to the requester whose request it answers.
module scr1_dmem_arb2
    import scr1_memif_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH = 4,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic                 rst_n,
    input  logic                 clk,

    input  logic                 s0_req,
    output logic                 s0_req_ack,
    input  type_scr1_mem_cmd_e   s0_cmd,
    input  type_scr1_mem_width_e s0_width,
    input  logic [31:0]          s0_addr,
    input  logic [31:0]          s0_wdata,
    output logic [31:0]          s0_rdata,
    output type_scr1_mem_resp_e  s0_resp,

    input  logic                 s1_req,
    output logic                 s1_req_ack,
    input  type_scr1_mem_cmd_e   s1_cmd,
    input  type_scr1_mem_width_e s1_width,
    input  logic [31:0]          s1_addr,
    input  logic [31:0]          s1_wdata,
    output logic [31:0]          s1_rdata,
    output type_scr1_mem_resp_e  s1_resp,

    output logic                 m_req,
    input  logic                 m_req_ack,
    output type_scr1_mem_cmd_e   m_cmd,
    output type_scr1_mem_width_e m_width,
    output logic [31:0]          m_addr,
    output logic [31:0]          m_wdata,
    input  logic [31:0]          m_rdata,
    input  type_scr1_mem_resp_e  m_resp,

    output logic                 busy
);

    localparam int unsigned PtrW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(OUTST_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(OUTST_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(OUTST_DEPTH - 1);

    logic [OUTST_DEPTH-1:0] tag_q, tag_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   rr_q, rr_d;

    logic stall;
    logic grant0;
    logic grant1;
    logic accept;
    logic resp_evt;
    logic head_id;

    // Request side: grant, forward and acknowledge with no added latency.
    always_comb begin
        stall      = (count_q == CntFull);
        // rr_q set means requester 1 holds round-robin priority.
        grant1     = s1_req & (~s0_req | (~FIXED_PRIO & rr_q));
        grant0     = s0_req & ~grant1;
        m_req      = (s0_req | s1_req) & ~stall;
        s0_req_ack = m_req_ack & grant0 & ~stall;
        s1_req_ack = m_req_ack & grant1 & ~stall;
        m_cmd      = grant1 ? s1_cmd   : s0_cmd;
        m_width    = grant1 ? s1_width : s0_width;
        m_addr     = grant1 ? s1_addr  : s0_addr;
        m_wdata    = grant1 ? s1_wdata : s0_wdata;
        accept     = m_req & m_req_ack;
    end

    // Response side: the head tag names the destination; orphans reach nobody.
    always_comb begin
        head_id  = tag_q[rd_ptr_q];
        resp_evt = (m_resp != SCR1_MEM_RESP_NOTRDY) & (count_q != '0);
        s0_resp  = (resp_evt & ~head_id) ? m_resp : SCR1_MEM_RESP_NOTRDY;
        s1_resp  = (resp_evt &  head_id) ? m_resp : SCR1_MEM_RESP_NOTRDY;
        s0_rdata = m_rdata;
        s1_rdata = m_rdata;
        busy     = (count_q != '0);
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        if (accept) begin
            tag_d[wr_ptr_q] = grant1;
            wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            rr_d            = ~grant1;
        end
        if (resp_evt) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({accept, resp_evt})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (count_q != CntFull));
    a_m_req_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown(m_req));
    a_ack0_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        s0_req_ack |-> s0_req);
    a_ack1_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        s1_req_ack |-> s1_req);
    a_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (m_resp != SCR1_MEM_RESP_NOTRDY) |-> (count_q != '0))
        else $warning("scr1_dmem_arb2: orphan bridge response ignored");
`endif

endmodule
